// File: rtl/disp_io_ctrl.sv
// rtl/disp_io_ctrl.sv - Z80 I/O-mapped seven-segment display and LED controller
// Captures CPU OUT cycles through synchronizers and a write FSM; drives digit data for sev_segdriver.
module disp_io_ctrl #(
    parameter logic [7:0] PORT_BASE = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iorq_n,
    input  logic        mreq_n,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic [15:0] address,
    input  logic [7:0]  dbus_out,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic [4:0]  data_digit0,
    output logic [4:0]  data_digit1,
    output logic [4:0]  data_digit2,
    output logic [4:0]  data_digit3,
    output logic [7:0]  led,
    output logic        wr_ack,
    output logic [7:0]  wr_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, WAIT_REL} state_t;

    state_t      state, state_nxt;
    logic        iorq_s1, iorq_s2, wr_s1, wr_s2;
    logic        mreq_s1, mreq_s2, mreq_d, mreq_fall;
    logic [7:0]  r0, r1, r3;
    logic [4:0]  r2;
    logic [15:0] snap;
    logic        port_match, commit_en;
    logic [15:0] digit_src;

    assign port_match = (address[7:2] == PORT_BASE[7:2]);
    assign commit_en  = (state == COMMIT) && port_match;

    // Strobes idle high, so the synchronizers reset to the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iorq_s1   <= 1'b1;
            iorq_s2   <= 1'b1;
            wr_s1     <= 1'b1;
            wr_s2     <= 1'b1;
            mreq_s1   <= 1'b1;
            mreq_s2   <= 1'b1;
            mreq_d    <= 1'b1;
            mreq_fall <= 1'b0;
        end else begin
            iorq_s1   <= iorq_n;
            iorq_s2   <= iorq_s1;
            wr_s1     <= wr_n;
            wr_s2     <= wr_s1;
            mreq_s1   <= mreq_n;
            mreq_s2   <= mreq_s1;
            mreq_d    <= mreq_s2;
            mreq_fall <= mreq_d & ~mreq_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // SETTLE also inspects the first sync stage so pulses under three cycles never commit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!iorq_s2 && !wr_s2) state_nxt = SETTLE;
            SETTLE:   if (iorq_s1 || wr_s1 || iorq_s2 || wr_s2) state_nxt = IDLE;
                      else state_nxt = COMMIT;
            COMMIT:   state_nxt = WAIT_REL;
            WAIT_REL: if (wr_s2 || iorq_s2) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0     <= 8'h00;
            r1     <= 8'h00;
            r2     <= 5'h00;
            r3     <= 8'h00;
            wr_ack <= 1'b0;
            wr_cnt <= 8'h00;
            snap   <= 16'h0000;
        end else begin
            wr_ack <= commit_en;
            if (commit_en) begin
                wr_cnt <= wr_cnt + 8'd1;
                case (address[1:0])
                    2'd0: r0 <= dbus_out;
                    2'd1: r1 <= dbus_out;
                    2'd2: r2 <= dbus_out[4:0];
                    default: r3 <= dbus_out;
                endcase
            end
            if (mreq_fall) snap <= address;
        end
    end

    assign digit_src   = r2[4] ? snap : {r1, r0};
    assign data_digit0 = {~r2[0], digit_src[3:0]};
    assign data_digit1 = {~r2[1], digit_src[7:4]};
    assign data_digit2 = {~r2[2], digit_src[11:8]};
    assign data_digit3 = {~r2[3], digit_src[15:12]};
    assign led         = r3;

    assign rd_hit = !iorq_n && !rd_n && (address[7:2] == PORT_BASE[7:2]);

    always_comb begin
        rd_data = 8'h00;
        case (address[1:0])
            2'd0:    rd_data = r0;
            2'd1:    rd_data = r1;
            2'd2:    rd_data = {3'b000, r2};
            default: rd_data = r3;
        endcase
    end

endmodule

// File: tb/tb_disp_io_ctrl.sv
// tb/tb_disp_io_ctrl.sv - randomized self-checking bench for disp_io_ctrl
// A register-level model tracks expected display, LED, count and snapshot state.
module tb_disp_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iorq_n, mreq_n, wr_n, rd_n;
    logic [15:0] address;
    logic [7:0]  dbus_out;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic [4:0]  dig0, dig1, dig2, dig3;
    logic [7:0]  led;
    logic        wr_ack;
    logic [7:0]  wr_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  m_r [4];
    int          m_cnt;
    logic [15:0] m_snap;
    int          valid_writes = 0;

    disp_io_ctrl #(.PORT_BASE(8'h10)) dut (
        .clk(clk), .rst_n(rst_n), .iorq_n(iorq_n), .mreq_n(mreq_n),
        .wr_n(wr_n), .rd_n(rd_n), .address(address), .dbus_out(dbus_out),
        .rd_data(rd_data), .rd_hit(rd_hit),
        .data_digit0(dig0), .data_digit1(dig1), .data_digit2(dig2), .data_digit3(dig3),
        .led(led), .wr_ack(wr_ack), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dut_digit(input int n);
        case (n)
            0: return dig0;
            1: return dig1;
            2: return dig2;
            default: return dig3;
        endcase
    endfunction

    function automatic logic [4:0] model_digit(input int n);
        logic [15:0] src;
        logic [3:0]  nib;
        src = m_r[2][4] ? m_snap : {m_r[1], m_r[0]};
        nib = src[4*n +: 4];
        return {~m_r[2][n], nib};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_cnt  = 0;
        m_snap = 16'h0000;
    endtask

    task automatic check_state(input string tag);
        for (int n = 0; n < 4; n++)
            chk($sformatf("%s digit%0d", tag, n), 32'(dut_digit(n)), 32'(model_digit(n)));
        chk({tag, " led"}, 32'(led), 32'(m_r[3]));
        chk({tag, " wr_cnt"}, 32'(wr_cnt), 32'(m_cnt % 256));
    endtask

    // OUT cycle: strobe low for w edges, then idle long enough for the FSM to return
    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int w);
        int  acks = 0;
        int  ack_at = -1;
        logic hit;
        address = a; dbus_out = d; iorq_n = 1'b0; wr_n = 1'b0;
        for (int c = 1; c <= w + 8; c++) begin
            @(posedge clk); #1;
            if (wr_ack) begin
                acks++;
                if (ack_at < 0) ack_at = c;
            end
            if (c == w) begin iorq_n = 1'b1; wr_n = 1'b1; end
        end
        hit = (a[7:2] == 6'h04) && (w >= 4);
        if (hit) begin
            m_r[a[1:0]] = (a[1:0] == 2'd2) ? (d & 8'h1F) : d;
            m_cnt++;
            valid_writes++;
            chk("ack edge", 32'(ack_at), 32'd5);
        end
        chk($sformatf("ack count a=%h w=%0d", a, w), 32'(acks), hit ? 32'd1 : 32'd0);
    endtask

    task automatic mem_cycle(input logic [15:0] a);
        address = a; mreq_n = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        mreq_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        m_snap = a;
    endtask

    task automatic io_read(input logic [15:0] a, input logic [7:0] exp_data, input logic exp_hit);
        address = a; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk($sformatf("rd_hit %h", a), 32'(rd_hit), 32'(exp_hit));
        if (exp_hit) chk($sformatf("rd_data %h", a), 32'(rd_data), 32'(exp_data));
        @(posedge clk); #1;
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    initial begin
        int ack_seen;
        logic [7:0] d;
        logic [15:0] a;
        int w, op;

        rst_n = 1'b0; iorq_n = 1'b1; mreq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        address = 16'h0; dbus_out = 8'h0;
        model_reset();

        // Reset held with random bus activity
        ack_seen = 0;
        for (int i = 0; i < 24; i++) begin
            iorq_n = 1'($urandom); wr_n = 1'($urandom); mreq_n = 1'($urandom);
            address = 16'($urandom); dbus_out = 8'($urandom);
            @(posedge clk); #1;
            if (wr_ack) ack_seen++;
        end
        chk("reset ack", 32'(ack_seen), 32'd0);
        check_state("reset");
        iorq_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1;
        address = 16'h0;
        #1;
        chk("reset rd_data", 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // CPU writes
        io_write(16'h0010, 8'hA5, 20);
        io_write(16'h0011, 8'h3C, 20);
        chk("d0", 32'(dig0), 32'h15);
        chk("d1", 32'(dig1), 32'h1A);
        chk("d2", 32'(dig2), 32'h1C);
        chk("d3", 32'(dig3), 32'h13);
        chk("cnt2", 32'(wr_cnt), 32'd2);

        // Decimal points, LEDs, then debug address mode
        io_write(16'h0012, 8'h05, 6);
        io_write(16'h0013, 8'h81, 6);
        check_state("dp led");
        io_write(16'h0012, 8'h10, 6);
        mem_cycle(16'hBEEF);
        chk("dbg d0", 32'(dig0), 32'h1F);
        chk("dbg d1", 32'(dig1), 32'h1E);
        chk("dbg d2", 32'(dig2), 32'h1E);
        chk("dbg d3", 32'(dig3), 32'h1B);
        check_state("debug");

        // Decode miss and glitches
        io_write(16'h0020, 8'hFF, 8);
        io_write(16'h0010, 8'h77, 2);
        io_write(16'h0011, 8'h66, 1);
        check_state("decode glitch");

        // Readback
        io_write(16'h0012, 8'hFF, 5);
        io_read(16'h0012, 8'h1F, 1'b1);
        io_read(16'h0030, 8'h00, 1'b0);
        io_read(16'hAB13, m_r[3], 1'b1);

        // Random traffic, long enough to wrap wr_cnt
        while (valid_writes < 270) begin
            op = int'($urandom_range(0, 9));
            d = 8'($urandom);
            a = 16'($urandom);
            if (op == 0) begin
                mem_cycle(a);
            end else if (op == 1) begin
                a[7:2] = 6'($urandom_range(5, 63));
                io_write(a, d, int'($urandom_range(4, 10)));
            end else if (op == 2) begin
                a[7:2] = 6'h04;
                io_write(a, d, int'($urandom_range(1, 2)));
            end else begin
                a[7:2] = 6'h04;
                io_write(a, d, int'($urandom_range(4, 12)));
            end
            check_state("rand");
        end
        chk("wrapped", 32'(m_cnt > 255), 32'd1);

        // Reset during COMMIT, strobe still low at release
        address = 16'h0010; dbus_out = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
        ack_seen = 0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midreset");
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (wr_ack) ack_seen++;
            if (c == 10) begin iorq_n = 1'b1; wr_n = 1'b1; end
        end
        m_r[0] = 8'h5A;
        m_cnt = 1;
        chk("midreset acks", 32'(ack_seen), 32'd1);
        check_state("after midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
